// File: rtl/rr_grant_fsm.sv
// ---------------------------------------------------------------------------
// rr_grant_fsm
//   Round-robin arbiter FSM sharing one downstream resource among N_REQ
//   requesters. One owner at a time, hold limit with preemption, and a
//   RELEASE + IDLE gap between owners. State encoding and owner index are
//   exported so external FSM properties can bind to them.
//
// Ports
//   clk      in   1       rising-edge clock
//   rst      in   1       asynchronous active-high reset
//   req      in   N_REQ   request vector, bit i = requester i wants the resource
//   gnt      out  N_REQ   one-hot grant, zero when no grant
//   owner    out  OW      index of current or most recent grantee
//   busy     out  1       high while in GRANT
//   preempt  out  1       one-cycle pulse in RELEASE after a hold-limit expiry
//   state    out  2       IDLE=00, GRANT=01, RELEASE=10 (11 unused)
// ---------------------------------------------------------------------------
module rr_grant_fsm #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  localparam int OW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [OW-1:0]    owner,
  output logic             busy,
  output logic             preempt,
  output logic [1:0]       state
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [OW-1:0] PTR_RST   = OW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RELEASE = 2'b10,
    ST_UNUSED  = 2'b11
  } state_e;

  state_e          state_q,    state_d;
  logic [OW-1:0]   owner_q,    owner_d;
  logic [OW-1:0]   last_ptr_q, last_ptr_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            preempt_q,  preempt_d;

  // Search last+1, last+2, ... wrapping, with last itself as final candidate,
  // so a lone persistent requester is regranted after its own release.
  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [OW-1:0]    last);
    logic          found;
    logic [OW-1:0] idx;
    int            tmp;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      tmp = (int'(last) + i) % N_REQ;
      idx = OW'(tmp);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      last_ptr_q <= PTR_RST;
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_ptr_q <= last_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_ptr_d = last_ptr_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = preempt_q;
    case (state_q)
      ST_IDLE: begin
        preempt_d = 1'b0;
        if (|req) begin
          owner_d    = rr_pick(req, last_ptr_q);
          hold_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[owner_q]) begin
          state_d   = ST_RELEASE;
          preempt_d = 1'b0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = ST_RELEASE;
          preempt_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_RELEASE: begin
        last_ptr_d = owner_q;
        preempt_d  = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        preempt_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state only; gnt/busy fall with async reset
  always_comb begin
    gnt     = '0;
    busy    = 1'b0;
    owner   = owner_q;
    preempt = preempt_q;
    state   = state_q;
    if (state_q == ST_GRANT) begin
      gnt[owner_q] = 1'b1;
      busy         = 1'b1;
    end
  end

endmodule
